mul2x2_seq_ctrl: RTL

- Sequencing controller that computes a WIDTH x WIDTH unsigned product with a single 2x2 multiplier slice.
- Splits each operand into 2-bit digits, issues one digit-pair multiply per clock, and shift-accumulates the partial products into a 2*WIDTH accumulator.
- Sits between a requester using a start/busy/done handshake and the shared 2x2 multiply datapath. Trades latency for area in wide multiplies.

---
 rtl/mul2x2_seq_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/mul2x2_seq_ctrl.sv
// Sequential WIDTH x WIDTH unsigned multiplier built around one 2x2 multiply slice.
// Digit pairs are issued one per clock and shift-accumulated into a 2*WIDTH accumulator.
module mul2x2_seq_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int unsigned Digits = WIDTH / 2;
   localparam int unsigned IdxW   = (Digits > 1) ? $clog2(Digits) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(Digits - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, product_q, product_d;
   logic [IdxW-1:0]    i_q, i_d, j_q, j_d;

   logic [1:0]         a_dig, b_dig;
   logic [3:0]         pp;
   logic [IdxW:0]      pos;
   logic [2*WIDTH-1:0] pp_ext, pp_shifted, acc_sum;

   // Digit select as an explicit mux so the slice sees only the active pair.
   always_comb begin
      a_dig = '0;
      b_dig = '0;
      for (int k = 0; k < Digits; k++) begin
         if (i_q == IdxW'(k)) a_dig = a_q[2*k +: 2];
         if (j_q == IdxW'(k)) b_dig = b_q[2*k +: 2];
      end
   end

   always_comb begin
      pp         = {2'b00, a_dig} * {2'b00, b_dig};
      pp_ext     = '0;
      pp_ext[3:0] = pp;
      pos        = {1'b0, i_q} + {1'b0, j_q};
      pp_shifted = pp_ext << {pos, 1'b0};
      acc_sum    = acc_q + pp_shifted;
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      product_d = product_q;
      i_d       = i_q;
      j_d       = j_q;
      unique case (state_q)
         StIdle, StDone: begin
            // DONE accepts start like IDLE so back-to-back requests lose no cycle.
            if (start) begin
               a_d     = a;
               b_d     = b;
               acc_d   = '0;
               i_d     = '0;
               j_d     = '0;
               state_d = StRun;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            acc_d = acc_sum;
            if (j_q == LastIdx) begin
               j_d = '0;
               if (i_q == LastIdx) begin
                  i_d       = '0;
                  product_d = acc_sum;
                  state_d   = StDone;
               end else begin
                  i_d = i_q + 1'b1;
               end
            end else begin
               j_d = j_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         product_q <= '0;
         i_q       <= '0;
         j_q       <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         i_q       <= i_d;
         j_q       <= j_d;
      end
   end

   assign busy    = (state_q == StRun);
   assign done    = (state_q == StDone);
   assign product = product_q;

endmodule
